// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM state encoding and sizing helper for alu_seq
//
// Purpose : opcode localparams, iterative-unit mode codes, FSM state type and
//           the counter-width helper used by alu_seq and alu_iter_muldiv.
// Ports   : none (package).
package alu_pkg;

    localparam logic [3:0] OP_LEFT = 4'h0;
    localparam logic [3:0] OP_IADD = 4'h1;
    localparam logic [3:0] OP_ISUB = 4'h2;
    localparam logic [3:0] OP_IMUL = 4'h3;
    localparam logic [3:0] OP_IDIV = 4'h4;
    localparam logic [3:0] OP_IREM = 4'h5;
    localparam logic [3:0] OP_BAND = 4'h9;
    localparam logic [3:0] OP_BIOR = 4'hA;
    localparam logic [3:0] OP_BXOR = 4'hB;
    localparam logic [3:0] OP_ISHL = 4'hC;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    // Iteration counter must hold WIDTH-1.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operation/result handshake bundle for alu_seq
//
// Purpose : groups the request side (in_valid/in_ready/alu_op/a/b/in_tag) and
//           the result side (out_valid/out_ready/c/ofl/err/out_tag).
// Modports: slave  - the ALU (accepts operations, produces results)
//           master - the pipeline around it (operand fetch and writeback)
interface alu_seq_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             ofl;
    logic             err;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, alu_op, a, b, in_tag, out_ready,
        output in_ready, out_valid, c, ofl, err, out_tag
    );

    modport master (
        output in_valid, alu_op, a, b, in_tag, out_ready,
        input  in_ready, out_valid, c, ofl, err, out_tag
    );
endinterface

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - iterative shift-add multiplier / restoring divider
//
// Purpose : one bit per clock, WIDTH steps per operation. The first step is
//           taken on the start edge, so done is raised in the cycle whose edge
//           performs the last step; res_hi/res_lo show that last step's
//           outcome combinationally so the caller can register it directly.
// Ports   : clk, rst   - clock, synchronous active-high reset
//           start      - begin an operation with a/b/mode
//           mode       - MODE_MUL or MODE_DIV
//           a, b       - multiplicand/multiplier or dividend/divisor
//           done       - final step happens on the coming edge
//           res_hi/lo  - product high/low, or remainder/quotient
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CW = cnt_w(WIDTH);

    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic             mode_q, busy_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] cur_hi, cur_lo, cur_opnd;
    logic             cur_mode;
    logic [WIDTH:0]   mul_sum, div_t, div_diff;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;

    always_comb begin
        // On the start edge the step operates on freshly presented operands.
        // Multiply: lo holds the multiplier, opnd the multiplicand.
        // Divide:   lo holds the dividend,   opnd the divisor.
        if (start) begin
            cur_hi   = '0;
            cur_lo   = (mode == MODE_DIV) ? a : b;
            cur_opnd = (mode == MODE_DIV) ? b : a;
            cur_mode = mode;
        end else begin
            cur_hi   = hi_q;
            cur_lo   = lo_q;
            cur_opnd = opnd_q;
            cur_mode = mode_q;
        end

        mul_sum  = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_opnd} : '0);
        div_t    = {cur_hi, cur_lo[WIDTH-1]};
        div_diff = div_t - {1'b0, cur_opnd};

        if (cur_mode == MODE_MUL) begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], cur_lo[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            nxt_hi = div_diff[WIDTH-1:0];
            nxt_lo = {cur_lo[WIDTH-2:0], 1'b1};
        end else begin
            nxt_hi = div_t[WIDTH-1:0];
            nxt_lo = {cur_lo[WIDTH-2:0], 1'b0};
        end
    end

    // Counter is WIDTH-1 after the start edge and reaches 0 on the final step.
    assign done   = busy_q && (cnt_q == CW'(1));
    assign res_hi = nxt_hi;
    assign res_lo = nxt_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            mode_q <= MODE_MUL;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            hi_q   <= nxt_hi;
            lo_q   <= nxt_lo;
            opnd_q <= cur_opnd;
            mode_q <= mode;
            busy_q <= 1'b1;
            cnt_q  <= CW'(WIDTH - 1);
        end else if (busy_q) begin
            hi_q  <= nxt_hi;
            lo_q  <= nxt_lo;
            cnt_q <= cnt_q - CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with single-cycle ops and iterative mul/div/rem
//
// Purpose : accepts one operation when in_valid && in_ready, returns c/ofl/err
//           with the caller's tag through a held output register.
// Ports   : clk, rst  - clock, synchronous active-high reset
//           bus       - alu_seq_if.slave (request and result handshakes)
//           flag_clr, sticky_ofl, sticky_err - only with ALU_SEQ_STICKY_EN:
//                       sticky flags set on hand-off of a result with ofl/err.
// Options : `define ALU_SEQ_STICKY_EN adds the sticky flag ports and logic.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
`ifdef ALU_SEQ_STICKY_EN
    ,
    input  logic       flag_clr,
    output logic       sticky_ofl,
    output logic       sticky_err
`endif
);
    state_t           state_q, state_n;

    logic [WIDTH-1:0] c_q;
    logic             ofl_q, err_q, out_valid_q;
    logic [TAG_W-1:0] out_tag_q, tag_q;
    logic             rem_q;

    logic             in_ready, accept, drain, div_op, go_iter;
    logic             iter_start, iter_mode, iter_done, load_out;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    logic [WIDTH:0]   add_w, sub_w;
    logic [WIDTH-1:0] neg_b;
    logic [WIDTH-1:0] sc_c;
    logic             sc_ofl, sc_err;

    logic [WIDTH-1:0] res_c;
    logic             res_ofl, res_err;
    logic [TAG_W-1:0] res_tag;

    // out_ready only matters when a held result can leave this cycle.
    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign drain    = out_valid_q && bus.out_ready;
    assign div_op   = (bus.alu_op == OP_IDIV) || (bus.alu_op == OP_IREM);
    // Divide by zero never iterates; it resolves as a single-cycle op.
    assign go_iter  = accept && ((bus.alu_op == OP_IMUL) || (div_op && (bus.b != '0)));

    always_comb begin
        add_w  = {1'b0, bus.a} + {1'b0, bus.b};
        sub_w  = {1'b0, bus.a} - {1'b0, bus.b};
        neg_b  = -bus.b;
        sc_c   = '0;
        sc_ofl = 1'b0;
        sc_err = 1'b0;
        case (bus.alu_op)
            OP_LEFT: sc_c = bus.a;
            OP_IADD: {sc_ofl, sc_c} = add_w;
            OP_ISUB: begin
                sc_c   = sub_w[WIDTH-1:0];
                sc_ofl = sub_w[WIDTH];
            end
            OP_IMUL: sc_c = '0;
            OP_IDIV: begin
                sc_c   = '1;
                sc_err = 1'b1;
            end
            OP_IREM: begin
                sc_c   = bus.a;
                sc_err = 1'b1;
            end
            OP_BAND: sc_c = bus.a & bus.b;
            OP_BIOR: sc_c = bus.a | bus.b;
            OP_BXOR: sc_c = bus.a ^ bus.b;
            // Shift amounts of WIDTH or more already produce zero; the most
            // negative b negates to itself, which is >= WIDTH as unsigned.
            OP_ISHL: sc_c = bus.b[WIDTH-1] ? (bus.a >> neg_b) : (bus.a << bus.b);
            default: sc_err = 1'b1;
        endcase
    end

    always_comb begin
        state_n    = state_q;
        iter_start = 1'b0;
        iter_mode  = MODE_MUL;
        load_out   = 1'b0;
        res_c      = sc_c;
        res_ofl    = sc_ofl;
        res_err    = sc_err;
        res_tag    = bus.in_tag;
        case (state_q)
            ST_IDLE: begin
                if (go_iter) begin
                    iter_start = 1'b1;
                    iter_mode  = (bus.alu_op == OP_IMUL) ? MODE_MUL : MODE_DIV;
                    state_n    = (bus.alu_op == OP_IMUL) ? ST_MUL : ST_DIV;
                end else if (accept) begin
                    load_out = 1'b1;
                end
            end
            ST_MUL: begin
                if (iter_done) begin
                    load_out = 1'b1;
                    res_c    = iter_lo;
                    res_ofl  = |iter_hi;
                    res_err  = 1'b0;
                    res_tag  = tag_q;
                    state_n  = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (iter_done) begin
                    load_out = 1'b1;
                    res_c    = rem_q ? iter_hi : iter_lo;
                    res_ofl  = 1'b0;
                    res_err  = 1'b0;
                    res_tag  = tag_q;
                    state_n  = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // The output register is never loaded while a result is still held:
    // iterative ops only start when the previous result drains, and
    // single-cycle loads require in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q         <= '0;
            ofl_q       <= 1'b0;
            err_q       <= 1'b0;
            out_tag_q   <= '0;
            out_valid_q <= 1'b0;
            tag_q       <= '0;
            rem_q       <= 1'b0;
        end else begin
            if (iter_start) begin
                tag_q <= bus.in_tag;
                rem_q <= (bus.alu_op == OP_IREM);
            end
            if (load_out) begin
                c_q         <= res_c;
                ofl_q       <= res_ofl;
                err_q       <= res_err;
                out_tag_q   <= res_tag;
                out_valid_q <= 1'b1;
            end else if (drain) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (iter_start),
        .mode   (iter_mode),
        .a      (bus.a),
        .b      (bus.b),
        .done   (iter_done),
        .res_hi (iter_hi),
        .res_lo (iter_lo)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;
    assign bus.ofl       = ofl_q;
    assign bus.err       = err_q;
    assign bus.out_tag   = out_tag_q;

`ifdef ALU_SEQ_STICKY_EN
    logic sticky_ofl_q, sticky_err_q;

    // A flag being set in the same cycle as flag_clr stays set.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ofl_q <= 1'b0;
            sticky_err_q <= 1'b0;
        end else begin
            if (drain && ofl_q) begin
                sticky_ofl_q <= 1'b1;
            end else if (flag_clr) begin
                sticky_ofl_q <= 1'b0;
            end
            if (drain && err_q) begin
                sticky_err_q <= 1'b1;
            end else if (flag_clr) begin
                sticky_err_q <= 1'b0;
            end
        end
    end

    assign sticky_ofl = sticky_ofl_q;
    assign sticky_err = sticky_err_q;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (WIDTH=16, TAG_W=4)
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 16;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W), .TAG_W(T)) bus ();

`ifdef ALU_SEQ_STICKY_EN
    logic flag_clr, sticky_ofl, sticky_err;
`endif

    alu_seq #(.WIDTH(W), .TAG_W(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ALU_SEQ_STICKY_EN
        ,
        .flag_clr   (flag_clr),
        .sticky_ofl (sticky_ofl),
        .sticky_err (sticky_err)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one operation with out_ready=1, check it is accepted, then check
    // the busy window, the result after lat cycles, and the drain after it.
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [T-1:0] tg, input int lat,
                          input logic [W-1:0] ec, input logic eo, input logic ee);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.a        = av;
        bus.b        = bv;
        bus.in_tag   = tg;
        #1;
        chk({name, "_in_ready"}, 32'(bus.in_ready), 1);
        tick;
        bus.in_valid = 1'b0;
        for (int i = 1; i < lat; i++) begin
            chk({name, "_busy_valid"}, 32'(bus.out_valid), 0);
            chk({name, "_busy_ready"}, 32'(bus.in_ready), 0);
            tick;
        end
        chk({name, "_valid"}, 32'(bus.out_valid), 1);
        chk({name, "_c"},     32'(bus.c),         32'(ec));
        chk({name, "_ofl"},   32'(bus.ofl),       32'(eo));
        chk({name, "_err"},   32'(bus.err),       32'(ee));
        chk({name, "_tag"},   32'(bus.out_tag),   32'(tg));
        tick;
        chk({name, "_drained"}, 32'(bus.out_valid), 0);
    endtask

    initial begin
        int seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_op    = 4'h0;
        bus.a         = '0;
        bus.b         = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
`ifdef ALU_SEQ_STICKY_EN
        flag_clr      = 1'b0;
`endif
        tick;
        tick;
        chk("rst_valid",    32'(bus.out_valid), 0);
        chk("rst_c",        32'(bus.c),         0);
        chk("rst_ofl",      32'(bus.ofl),       0);
        chk("rst_err",      32'(bus.err),       0);
        chk("rst_tag",      32'(bus.out_tag),   0);
        chk("rst_in_ready", 32'(bus.in_ready),  1);
        rst = 1'b0;
        tick;

        run_op("iadd_carry", OP_IADD, 16'hFFFF, 16'h0001, 4'h1, 1,  16'h0000, 1'b1, 1'b0);
        run_op("imul_ovf",   OP_IMUL, 16'h0100, 16'h0100, 4'h3, 16, 16'h0000, 1'b1, 1'b0);
        run_op("imul_small", OP_IMUL, 16'h0012, 16'h0034, 4'h2, 16, 16'h03A8, 1'b0, 1'b0);
        run_op("idiv_zero",  OP_IDIV, 16'h0007, 16'h0000, 4'h4, 1,  16'hFFFF, 1'b0, 1'b1);
        run_op("irem_zero",  OP_IREM, 16'h0007, 16'h0000, 4'h4, 1,  16'h0007, 1'b0, 1'b1);
        run_op("irem",       OP_IREM, 16'h0007, 16'h0002, 4'h5, 16, 16'h0001, 1'b0, 1'b0);
        run_op("idiv",       OP_IDIV, 16'h0064, 16'h0007, 4'h6, 16, 16'h000E, 1'b0, 1'b0);
        run_op("shr4",       OP_ISHL, 16'h00F0, 16'hFFFC, 4'h7, 1,  16'h000F, 1'b0, 1'b0);
        run_op("shl16",      OP_ISHL, 16'h00F0, 16'h0010, 4'h8, 1,  16'h0000, 1'b0, 1'b0);
        run_op("shl4",       OP_ISHL, 16'h00F0, 16'h0004, 4'h9, 1,  16'h0F00, 1'b0, 1'b0);
        run_op("illegal7",   4'h7,    16'h1234, 16'h5678, 4'hA, 1,  16'h0000, 1'b0, 1'b1);
        run_op("isub_borrow",OP_ISUB, 16'h0003, 16'h0005, 4'hB, 1,  16'hFFFE, 1'b1, 1'b0);
        run_op("left",       OP_LEFT, 16'h1234, 16'hFFFF, 4'hC, 1,  16'h1234, 1'b0, 1'b0);
        run_op("bxor",       OP_BXOR, 16'h00FF, 16'h0F0F, 4'hD, 1,  16'h0FF0, 1'b0, 1'b0);
        run_op("band",       OP_BAND, 16'h00FF, 16'h0F0F, 4'hE, 1,  16'h000F, 1'b0, 1'b0);
        run_op("bior",       OP_BIOR, 16'h00FF, 16'h0F0F, 4'hF, 1,  16'h0FFF, 1'b0, 1'b0);

        // Back-to-back single-cycle ops: one result per cycle.
        bus.in_valid = 1'b1;
        bus.alu_op   = OP_IADD;
        bus.a        = 16'h0001;
        bus.b        = 16'h0002;
        bus.in_tag   = 4'h5;
        tick;
        chk("b2b1_valid", 32'(bus.out_valid), 1);
        chk("b2b1_c",     32'(bus.c),         32'h0003);
        chk("b2b1_tag",   32'(bus.out_tag),   32'h5);
        bus.a      = 16'h0010;
        bus.b      = 16'h0020;
        bus.in_tag = 4'h6;
        #1;
        chk("b2b2_in_ready", 32'(bus.in_ready), 1);
        tick;
        chk("b2b2_valid", 32'(bus.out_valid), 1);
        chk("b2b2_c",     32'(bus.c),         32'h0030);
        chk("b2b2_tag",   32'(bus.out_tag),   32'h6);
        bus.a      = 16'hFFFF;
        bus.b      = 16'hFFFF;
        bus.in_tag = 4'h7;
        tick;
        chk("b2b3_c",     32'(bus.c),       32'hFFFE);
        chk("b2b3_ofl",   32'(bus.ofl),     1);
        chk("b2b3_tag",   32'(bus.out_tag), 32'h7);
        bus.in_valid = 1'b0;
        tick;
        chk("b2b_drained", 32'(bus.out_valid), 0);

        // Back-pressure: result held, next op stalled until out_ready returns.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.alu_op    = OP_IADD;
        bus.a         = 16'h0005;
        bus.b         = 16'h0006;
        bus.in_tag    = 4'h1;
        tick;
        bus.a      = 16'h0001;
        bus.b      = 16'h0001;
        bus.in_tag = 4'h2;
        for (int i = 0; i < 3; i++) begin
            chk("hold_in_ready", 32'(bus.in_ready),  0);
            chk("hold_valid",    32'(bus.out_valid), 1);
            chk("hold_c",        32'(bus.c),         32'h000B);
            chk("hold_tag",      32'(bus.out_tag),   32'h1);
            tick;
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 1);
        tick;
        chk("release_valid", 32'(bus.out_valid), 1);
        chk("release_c",     32'(bus.c),         32'h0002);
        chk("release_tag",   32'(bus.out_tag),   32'h2);
        bus.in_valid = 1'b0;
        tick;
        chk("release_drained", 32'(bus.out_valid), 0);

        // Reset five cycles into a divide aborts it without a result.
        bus.in_valid = 1'b1;
        bus.alu_op   = OP_IDIV;
        bus.a        = 16'h0064;
        bus.b        = 16'h0007;
        bus.in_tag   = 4'h9;
        tick;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        chk("abort_busy", 32'(bus.in_ready), 0);
        rst = 1'b1;
        tick;
        chk("abort_valid",    32'(bus.out_valid), 0);
        chk("abort_in_ready", 32'(bus.in_ready),  1);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            tick;
            if (bus.out_valid) seen++;
        end
        chk("abort_no_result", 32'(seen), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: observed no finish, expected finish within 1 ms");
        $fatal(1, "timeout");
    end
endmodule
